// File: rtl/i2c_reg_write_master_if.sv
// rtl/i2c_reg_write_master_if.sv - sequencer-side request/status bundle for i2c_reg_write_master
//   iGO   : transaction request level, held by the sequencer until oEND
//   iDATA : {slave_addr, reg_addr, data_hi, data_lo}, sampled on acceptance
//   oEND  : transaction complete, held until iGO drops
//   oACK  : 1 = at least one NACK seen in the last transaction
//   oBUSY : transaction in progress
//   modport master : sequencer side; modport slave : write-master side
interface i2c_reg_write_master_if;
    logic        iGO;
    logic [31:0] iDATA;
    logic        oEND;
    logic        oACK;
    logic        oBUSY;

    modport master (
        output iGO,
        output iDATA,
        input  oEND,
        input  oACK,
        input  oBUSY
    );

    modport slave (
        input  iGO,
        input  iDATA,
        output oEND,
        output oACK,
        output oBUSY
    );
endinterface

// File: rtl/i2c_reg_write_master.sv
// rtl/i2c_reg_write_master.sv - byte-level I2C 4-byte register write master
//   iCLK     : system clock
//   iRST_N   : asynchronous active-low reset, releases the bus immediately
//   seq      : request/status bundle (iGO, iDATA, oEND, oACK, oBUSY)
//   I2C_SCLK : SCL, push-pull
//   I2C_SDAT : SDA, open-drain (drives 0 or Z only)
//   Optional macro I2C_NACK_ABORT_EN: a NACK in any ACK slot jumps straight to STOP.
module i2c_reg_write_master #(
    parameter int CLK_FREQ = 50000000,
    parameter int I2C_FREQ = 20000,
    parameter int QTR_DIV  = CLK_FREQ / (4 * I2C_FREQ)
) (
    input  logic                         iCLK,
    input  logic                         iRST_N,
    i2c_reg_write_master_if.slave        seq,
    output logic                         I2C_SCLK,
    inout  wire                          I2C_SDAT
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        BIT   = 3'd2,
        ACK   = 3'd3,
        STOP  = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [15:0] QMAX = 16'(QTR_DIV - 1);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] qcnt;
    logic [1:0]  q;
    logic        qtick;
    logic        eop;
    logic [31:0] shreg;
    logic [2:0]  bit_cnt;
    logic [1:0]  byte_cnt;
    logic        ack_r;
    logic        accept;
    logic        abort;
    logic        scl_d;
    logic        sda_oe_d;
    logic        scl_q;
    logic        sda_oe_q;
    logic        sda_in;

    // quarter-bit tick; eop marks the last tick of a bit period
    assign qtick  = (state != IDLE) && (qcnt == QMAX);
    assign eop    = qtick && (q == 2'd3);
    assign accept = (state == IDLE) && seq.iGO && !seq.oEND;
    assign sda_in = I2C_SDAT;

`ifdef I2C_NACK_ABORT_EN
    // ack_r is set at q2 of the slot; at its eop it can only reflect this slot,
    // because any earlier NACK would already have diverted to STOP
    assign abort = ack_r;
`else
    assign abort = 1'b0;
`endif

    // state register
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = START;
            START: if (eop) state_nxt = BIT;
            BIT:   if (eop && (bit_cnt == 3'd0)) state_nxt = ACK;
            ACK: begin
                if (eop) begin
                    if (abort || (byte_cnt == 2'd3)) state_nxt = STOP;
                    else                             state_nxt = BIT;
                end
            end
            STOP:  if (eop) state_nxt = DONE;
            DONE:  if (!seq.iGO) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // output logic: SCL low in q0/q1 of data/ack/stop periods, high otherwise
    always_comb begin
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
        case (state)
            START: sda_oe_d = q[1];
            BIT: begin
                scl_d    = q[1];
                sda_oe_d = !shreg[31];
            end
            ACK:   scl_d = q[1];
            STOP: begin
                scl_d    = q[1];
                sda_oe_d = (q != 2'd3);
            end
            default: begin
                scl_d    = 1'b1;
                sda_oe_d = 1'b0;
            end
        endcase
    end

    // pin registers keep SCL/SDA glitch-free across state changes
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            scl_q    <= 1'b1;
            sda_oe_q <= 1'b0;
        end else begin
            scl_q    <= scl_d;
            sda_oe_q <= sda_oe_d;
        end
    end

    // quarter-bit timebase, held cleared while idle
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            qcnt <= 16'd0;
            q    <= 2'd0;
        end else if (state == IDLE) begin
            qcnt <= 16'd0;
            q    <= 2'd0;
        end else if (qtick) begin
            qcnt <= 16'd0;
            q    <= q + 2'd1;
        end else begin
            qcnt <= qcnt + 16'd1;
        end
    end

    // shift register, bit/byte counters and sticky NACK flag
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            shreg    <= 32'd0;
            bit_cnt  <= 3'd0;
            byte_cnt <= 2'd0;
            ack_r    <= 1'b0;
        end else begin
            if (accept) begin
                shreg    <= seq.iDATA;
                bit_cnt  <= 3'd7;
                byte_cnt <= 2'd0;
                ack_r    <= 1'b0;
            end
            if ((state == BIT) && eop) begin
                shreg   <= {shreg[30:0], 1'b0};
                bit_cnt <= bit_cnt - 3'd1;  // wraps back to 7 for the next byte
            end
            if ((state == ACK) && qtick && (q == 2'd2) && sda_in) begin
                ack_r <= 1'b1;
            end
            if ((state == ACK) && eop && (byte_cnt != 2'd3)) begin
                byte_cnt <= byte_cnt + 2'd1;
            end
        end
    end

    assign I2C_SCLK  = scl_q;
    assign I2C_SDAT  = sda_oe_q ? 1'b0 : 1'bz;
    assign seq.oEND  = (state == DONE);
    assign seq.oBUSY = (state == START) || (state == BIT) || (state == ACK) || (state == STOP);
    assign seq.oACK  = ack_r;

endmodule

// File: tb/tb_i2c_reg_write_master.sv
// tb/tb_i2c_reg_write_master.sv - directed self-checking bench for i2c_reg_write_master
module tb_i2c_reg_write_master;

    localparam int Q        = 2;
    localparam int LAT_FULL = 152 * Q;
`ifdef I2C_NACK_ABORT_EN
    localparam int LAT_NACK0   = 44 * Q;
    localparam int NBYTES_NACK0 = 1;
`else
    localparam int LAT_NACK0   = 152 * Q;
    localparam int NBYTES_NACK0 = 4;
`endif

    logic iCLK = 1'b0;
    logic iRST_N = 1'b0;
    wire  I2C_SCLK;
    wire  I2C_SDAT;
    logic slave_low = 1'b0;
    int   cyc = 0;

    int n_vec = 0;
    int n_err = 0;

    i2c_reg_write_master_if bus ();

    pullup (I2C_SDAT);
    assign I2C_SDAT = slave_low ? 1'b0 : 1'bz;

    i2c_reg_write_master #(
        .CLK_FREQ(50000000),
        .I2C_FREQ(20000),
        .QTR_DIV (Q)
    ) dut (
        .iCLK    (iCLK),
        .iRST_N  (iRST_N),
        .seq     (bus),
        .I2C_SCLK(I2C_SCLK),
        .I2C_SDAT(I2C_SDAT)
    );

    always #5 iCLK = ~iCLK;
    always @(posedge iCLK) cyc <= cyc + 1;

    // pin-level slave: detects START/STOP, samples bits on SCL rise,
    // drives ACK per nack_mask after the 8th bit
    logic [3:0] nack_mask = 4'b0000;
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    logic       active = 1'b0;
    int         rcnt = 0;
    int         byte_idx = 0;
    int         nbytes = 0;
    logic [7:0] cur_byte = 8'd0;
    logic [7:0] rx [4];
    int         start_cnt = 0;
    int         stop_cnt = 0;
    int         last_rise = 0;
    bit         have_rise = 0;
    int         per_min = 1000000;
    int         per_max = 0;

    always begin
        logic scl;
        logic sda;
        @(posedge iCLK);
        #1;
        scl = I2C_SCLK;
        sda = (I2C_SDAT === 1'b0) ? 1'b0 : 1'b1;
        if (prev_scl && scl && prev_sda && !sda) begin
            start_cnt++;
            active    = 1'b1;
            rcnt      = 0;
            byte_idx  = 0;
            nbytes    = 0;
            slave_low = 1'b0;
            have_rise = 0;
            per_min   = 1000000;
            per_max   = 0;
        end else if (prev_scl && scl && !prev_sda && sda) begin
            stop_cnt++;
            active    = 1'b0;
            slave_low = 1'b0;
        end else if (active) begin
            if (!prev_scl && scl) begin
                if (have_rise) begin
                    if (cyc - last_rise < per_min) per_min = cyc - last_rise;
                    if (cyc - last_rise > per_max) per_max = cyc - last_rise;
                end
                last_rise = cyc;
                have_rise = 1;
                if (rcnt < 8) cur_byte = {cur_byte[6:0], sda};
                rcnt++;
            end else if (prev_scl && !scl) begin
                if (rcnt == 8) begin
                    if (byte_idx < 4) begin
                        rx[byte_idx] = cur_byte;
                        slave_low    = !nack_mask[byte_idx];
                    end
                    nbytes++;
                end else if (rcnt == 9) begin
                    slave_low = 1'b0;
                    rcnt      = 0;
                    byte_idx++;
                end
            end
        end
        prev_scl = scl;
        prev_sda = sda;
    end

    // raise iGO with data, scramble iDATA after acceptance, wait for oEND
    task automatic run_txn(input logic [31:0] data, input logic [3:0] mask,
                           output int lat, output bit timed_out);
        int c0;
        timed_out = 1;
        nack_mask = mask;
        @(negedge iCLK);
        bus.iGO   = 1'b1;
        bus.iDATA = data;
        c0 = cyc;
        lat = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge iCLK);
            if (i == 1) bus.iDATA = ~data;
            if (bus.oEND) begin
                timed_out = 0;
                lat = cyc - c0 - 1;
                break;
            end
        end
    endtask

    task automatic drop_go();
        @(negedge iCLK);
        bus.iGO = 1'b0;
        @(negedge iCLK);
    endtask

    task automatic test_reset();
        bus.iGO   = 1'b0;
        bus.iDATA = 32'd0;
        iRST_N    = 1'b0;
        repeat (4) @(negedge iCLK);
        n_vec++; if (bus.oEND !== 1'b0) begin n_err++; $display("FAIL rst_oend got=%b exp=0", bus.oEND); end
        n_vec++; if (bus.oACK !== 1'b0) begin n_err++; $display("FAIL rst_oack got=%b exp=0", bus.oACK); end
        n_vec++; if (bus.oBUSY !== 1'b0) begin n_err++; $display("FAIL rst_obusy got=%b exp=0", bus.oBUSY); end
        n_vec++; if (I2C_SCLK !== 1'b1) begin n_err++; $display("FAIL rst_scl got=%b exp=1", I2C_SCLK); end
        n_vec++; if (I2C_SDAT !== 1'b1) begin n_err++; $display("FAIL rst_sda got=%b exp=1", I2C_SDAT); end
        iRST_N = 1'b1;
        repeat (10) @(negedge iCLK);
        n_vec++; if (I2C_SCLK !== 1'b1 || bus.oBUSY !== 1'b0) begin
            n_err++; $display("FAIL idle_after_rst scl=%b busy=%b exp scl=1 busy=0", I2C_SCLK, bus.oBUSY);
        end
    endtask

    task automatic test_ack_all();
        int lat; bit to; int s0; int p0;
        s0 = start_cnt; p0 = stop_cnt;
        run_txn(32'hBA09_0450, 4'b0000, lat, to);
        n_vec++; if (to) begin n_err++; $display("FAIL ack_all_timeout got=timeout exp=oEND"); end
        n_vec++; if (lat != LAT_FULL) begin n_err++; $display("FAIL ack_all_latency got=%0d exp=%0d", lat, LAT_FULL); end
        n_vec++; if (bus.oACK !== 1'b0) begin n_err++; $display("FAIL ack_all_oack got=%b exp=0", bus.oACK); end
        n_vec++; if (bus.oBUSY !== 1'b0) begin n_err++; $display("FAIL ack_all_obusy got=%b exp=0", bus.oBUSY); end
        n_vec++; if (nbytes != 4) begin n_err++; $display("FAIL ack_all_nbytes got=%0d exp=4", nbytes); end
        n_vec++; if (rx[0] !== 8'hBA) begin n_err++; $display("FAIL ack_all_byte0 got=%h exp=ba", rx[0]); end
        n_vec++; if (rx[1] !== 8'h09) begin n_err++; $display("FAIL ack_all_byte1 got=%h exp=09", rx[1]); end
        n_vec++; if (rx[2] !== 8'h04) begin n_err++; $display("FAIL ack_all_byte2 got=%h exp=04", rx[2]); end
        n_vec++; if (rx[3] !== 8'h50) begin n_err++; $display("FAIL ack_all_byte3 got=%h exp=50", rx[3]); end
        n_vec++; if (start_cnt - s0 != 1) begin n_err++; $display("FAIL ack_all_starts got=%0d exp=1", start_cnt - s0); end
        n_vec++; if (stop_cnt - p0 != 1) begin n_err++; $display("FAIL ack_all_stops got=%0d exp=1", stop_cnt - p0); end
        n_vec++; if (per_min != 8 || per_max != 8) begin
            n_err++; $display("FAIL scl_period got min=%0d max=%0d exp=8", per_min, per_max);
        end
        drop_go();
        n_vec++; if (bus.oEND !== 1'b0) begin n_err++; $display("FAIL ack_all_oend_clear got=%b exp=0", bus.oEND); end
    endtask

    task automatic test_nack_addr();
        int lat; bit to; int p0;
        p0 = stop_cnt;
        run_txn(32'h3C11_2233, 4'b0001, lat, to);
        n_vec++; if (to) begin n_err++; $display("FAIL nack_addr_timeout got=timeout exp=oEND"); end
        n_vec++; if (lat != LAT_NACK0) begin n_err++; $display("FAIL nack_addr_latency got=%0d exp=%0d", lat, LAT_NACK0); end
        n_vec++; if (bus.oACK !== 1'b1) begin n_err++; $display("FAIL nack_addr_oack got=%b exp=1", bus.oACK); end
        n_vec++; if (nbytes != NBYTES_NACK0) begin n_err++; $display("FAIL nack_addr_nbytes got=%0d exp=%0d", nbytes, NBYTES_NACK0); end
        n_vec++; if (rx[0] !== 8'h3C) begin n_err++; $display("FAIL nack_addr_byte0 got=%h exp=3c", rx[0]); end
        n_vec++; if (stop_cnt - p0 != 1) begin n_err++; $display("FAIL nack_addr_stops got=%0d exp=1", stop_cnt - p0); end
        drop_go();
        n_vec++; if (bus.oACK !== 1'b1) begin n_err++; $display("FAIL nack_addr_oack_hold got=%b exp=1", bus.oACK); end
    endtask

    task automatic test_nack_data();
        int lat; bit to;
        run_txn(32'h1234_5678, 4'b1000, lat, to);
        n_vec++; if (to || lat != LAT_FULL) begin n_err++; $display("FAIL nack_data_latency got=%0d exp=%0d", lat, LAT_FULL); end
        n_vec++; if (bus.oACK !== 1'b1) begin n_err++; $display("FAIL nack_data_oack got=%b exp=1", bus.oACK); end
        n_vec++; if (rx[1] !== 8'h34 || rx[3] !== 8'h78) begin
            n_err++; $display("FAIL nack_data_bytes got=%h/%h exp=34/78", rx[1], rx[3]);
        end
        drop_go();
    endtask

    task automatic test_hold_go();
        int lat; bit to; int s0; int bad;
        run_txn(32'h6601_ABCD, 4'b0000, lat, to);
        n_vec++; if (to) begin n_err++; $display("FAIL hold_timeout got=timeout exp=oEND"); end
        n_vec++; if (bus.oACK !== 1'b0) begin n_err++; $display("FAIL hold_oack_cleared got=%b exp=0", bus.oACK); end
        s0 = start_cnt;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge iCLK);
            if (bus.oEND !== 1'b1) bad++;
        end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL hold_oend got=%0d low cycles exp=0", bad); end
        n_vec++; if (start_cnt != s0) begin n_err++; $display("FAIL hold_no_restart got=%0d exp=%0d", start_cnt, s0); end
        drop_go();
        n_vec++; if (bus.oEND !== 1'b0) begin n_err++; $display("FAIL hold_oend_clear got=%b exp=0", bus.oEND); end
        run_txn(32'h6602_0F0F, 4'b0000, lat, to);
        n_vec++; if (start_cnt - s0 != 1) begin n_err++; $display("FAIL hold_restart got=%0d exp=1", start_cnt - s0); end
        n_vec++; if (rx[3] !== 8'h0F) begin n_err++; $display("FAIL hold_restart_byte3 got=%h exp=0f", rx[3]); end
        drop_go();
    endtask

    task automatic test_go_drop();
        int c0; int lat; bit to;
        nack_mask = 4'b0000;
        @(negedge iCLK);
        bus.iGO   = 1'b1;
        bus.iDATA = 32'hC0DE_7E57;
        c0 = cyc;
        repeat (20 * Q) @(negedge iCLK);
        bus.iGO = 1'b0;
        to = 1; lat = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge iCLK);
            if (bus.oEND) begin to = 0; lat = cyc - c0 - 1; break; end
        end
        n_vec++; if (to || lat != LAT_FULL) begin n_err++; $display("FAIL go_drop_latency got=%0d exp=%0d", lat, LAT_FULL); end
        n_vec++; if (rx[0] !== 8'hC0 || rx[3] !== 8'h57) begin
            n_err++; $display("FAIL go_drop_bytes got=%h/%h exp=c0/57", rx[0], rx[3]);
        end
        @(negedge iCLK);
        n_vec++; if (bus.oEND !== 1'b0) begin n_err++; $display("FAIL go_drop_pulse got=%b exp=0", bus.oEND); end
        n_vec++; if (bus.oBUSY !== 1'b0 || I2C_SCLK !== 1'b1) begin
            n_err++; $display("FAIL go_drop_idle busy=%b scl=%b exp busy=0 scl=1", bus.oBUSY, I2C_SCLK);
        end
    endtask

    task automatic test_reset_mid();
        int lat; bit to; int s0; bit reached;
        nack_mask = 4'b0000;
        @(negedge iCLK);
        bus.iGO   = 1'b1;
        bus.iDATA = 32'hA5C3_0F81;
        reached = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge iCLK);
            if (byte_idx == 1 && rcnt == 3) begin reached = 1; break; end
        end
        n_vec++; if (!reached) begin n_err++; $display("FAIL rst_mid_reach got=timeout exp=byte1"); end
        iRST_N = 1'b0;
        #1;
        n_vec++; if (I2C_SCLK !== 1'b1) begin n_err++; $display("FAIL rst_mid_scl got=%b exp=1", I2C_SCLK); end
        n_vec++; if (I2C_SDAT !== 1'b1) begin n_err++; $display("FAIL rst_mid_sda got=%b exp=1", I2C_SDAT); end
        n_vec++; if (bus.oBUSY !== 1'b0 || bus.oEND !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_status busy=%b end=%b exp=0/0", bus.oBUSY, bus.oEND);
        end
        bus.iGO = 1'b0;
        repeat (3) @(negedge iCLK);
        iRST_N = 1'b1;
        repeat (3) @(negedge iCLK);
        s0 = start_cnt;
        run_txn(32'h5A3C_F018, 4'b0000, lat, to);
        n_vec++; if (to || lat != LAT_FULL) begin n_err++; $display("FAIL rst_mid_relat got=%0d exp=%0d", lat, LAT_FULL); end
        n_vec++; if (start_cnt - s0 != 1) begin n_err++; $display("FAIL rst_mid_start got=%0d exp=1", start_cnt - s0); end
        n_vec++; if (rx[0] !== 8'h5A || rx[1] !== 8'h3C || rx[2] !== 8'hF0 || rx[3] !== 8'h18) begin
            n_err++; $display("FAIL rst_mid_bytes got=%h%h%h%h exp=5a3cf018", rx[0], rx[1], rx[2], rx[3]);
        end
        n_vec++; if (bus.oACK !== 1'b0) begin n_err++; $display("FAIL rst_mid_oack got=%b exp=0", bus.oACK); end
        drop_go();
    endtask

    initial begin
        test_reset();
        test_ack_all();
        test_nack_addr();
        test_nack_data();
        test_hold_go();
        test_go_drop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
